// File: rtl/frame_buffer_precheck_collector_pkg.sv
// Shared types and default widths for the frame-buffer pre-check collector slice.
package fb_precheck_pkg;

   localparam int PRECHECKLEN_DEFAULT = 8;
   localparam int ID_W                = 4;
   localparam int COLOUR_W            = 6;
   localparam int CNT_W               = 4;

   typedef enum logic {
      SYNC  = 1'b0,
      ACCUM = 1'b1
   } fsm_state_t;

   typedef struct packed {
      logic                valid;
      logic [ID_W-1:0]     id;
      logic [COLOUR_W-1:0] colour;
      logic [3:0]          slot;
   } precheck_hit_t;

endpackage

// File: rtl/frame_buffer_precheck_collector_if.sv
// Bundle between the pre-check counter/entity hit source (master) and the collector (slave).
interface frame_buffer_precheck_collector_if #(
   parameter int ID_W     = fb_precheck_pkg::ID_W,
   parameter int COLOUR_W = fb_precheck_pkg::COLOUR_W,
   parameter int CNT_W    = fb_precheck_pkg::CNT_W
);
   logic [3:0]          buffer_counter;
   logic                buffer_reset;
   logic                hit_in;
   logic [ID_W-1:0]     hit_id;
   logic [COLOUR_W-1:0] hit_colour;

   logic                out_valid;
   logic                out_hit;
   logic [ID_W-1:0]     out_id;
   logic [COLOUR_W-1:0] out_colour;
   logic [3:0]          out_slot;
   logic [CNT_W-1:0]    out_hit_count;
   logic                out_collision;
   logic                overrun;

   modport master (
      output buffer_counter, buffer_reset, hit_in, hit_id, hit_colour,
      input  out_valid, out_hit, out_id, out_colour, out_slot,
             out_hit_count, out_collision, overrun
   );

   modport slave (
      input  buffer_counter, buffer_reset, hit_in, hit_id, hit_colour,
      output out_valid, out_hit, out_id, out_colour, out_slot,
             out_hit_count, out_collision, overrun
   );
endinterface

// File: rtl/frame_buffer_precheck_collector_accumulator.sv
// First-hit capture and saturating hit counter for one pre-check window; clear wins over en.
module precheck_hit_accumulator
   import fb_precheck_pkg::*;
(
   input  logic                clk,
   input  logic                clear,
   input  logic                en,
   input  logic [ID_W-1:0]     hit_id,
   input  logic [COLOUR_W-1:0] hit_colour,
   input  logic [3:0]          slot,
   output precheck_hit_t       held_p0,
   output logic [CNT_W-1:0]    count_p0
);

   always_ff @(posedge clk) begin
      if (clear) begin
         held_p0  <= '0;
         count_p0 <= '0;
      end else if (en) begin
         // Lowest slot wins, so only the first hit of the window is kept.
         if (!held_p0.valid)
            held_p0 <= '{valid: 1'b1, id: hit_id, colour: hit_colour, slot: slot};
         if (count_p0 != '1)
            count_p0 <= count_p0 + 1'b1;
      end
   end

endmodule

// File: rtl/frame_buffer_precheck_collector.sv
// Collects per-slot hits into one registered snapshot per window.
// Optional sticky protocol check enabled by PRECHECK_OVERRUN_DET_EN.
module frame_buffer_precheck_collector #(
   parameter int PRECHECKLEN = fb_precheck_pkg::PRECHECKLEN_DEFAULT,
   parameter int ID_W        = fb_precheck_pkg::ID_W,
   parameter int COLOUR_W    = fb_precheck_pkg::COLOUR_W,
   parameter int CNT_W       = fb_precheck_pkg::CNT_W
) (
   input logic                              clk,
   input logic                              reset,
   frame_buffer_precheck_collector_if.slave bus
);
   import fb_precheck_pkg::*;

   fsm_state_t       state;
   precheck_hit_t    acc_hit_p0;
   logic [CNT_W-1:0] acc_count_p0;
   logic             slot_valid;
   logic             commit;
   logic             accum_en;
   logic             acc_clear;

   assign slot_valid = bus.buffer_counter < 4'(PRECHECKLEN);
   assign commit     = (state == ACCUM) && bus.buffer_reset;
   // A hit arriving with the commit pulse is dropped; slot 0 counts on the SYNC exit cycle.
   assign accum_en   = bus.hit_in && slot_valid && !commit &&
                       ((state == ACCUM) || (bus.buffer_counter == 4'd0));
   assign acc_clear  = reset || commit;

   precheck_hit_accumulator u_acc (
      .clk        (clk),
      .clear      (acc_clear),
      .en         (accum_en),
      .hit_id     (bus.hit_id),
      .hit_colour (bus.hit_colour),
      .slot       (bus.buffer_counter),
      .held_p0    (acc_hit_p0),
      .count_p0   (acc_count_p0)
   );

   // Snapshot stage: outputs change only at a commit edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= SYNC;
         bus.out_valid     <= 1'b0;
         bus.out_hit       <= 1'b0;
         bus.out_id        <= '0;
         bus.out_colour    <= '0;
         bus.out_slot      <= '0;
         bus.out_hit_count <= '0;
         bus.out_collision <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         case (state)
            SYNC: begin
               if (bus.buffer_counter == 4'd0)
                  state <= ACCUM;
            end
            ACCUM: begin
               if (bus.buffer_reset) begin
                  bus.out_valid     <= 1'b1;
                  bus.out_hit       <= acc_hit_p0.valid;
                  bus.out_id        <= acc_hit_p0.id;
                  bus.out_colour    <= acc_hit_p0.colour;
                  bus.out_slot      <= acc_hit_p0.slot;
                  bus.out_hit_count <= acc_count_p0;
                  bus.out_collision <= acc_count_p0 >= CNT_W'(2);
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

`ifdef PRECHECK_OVERRUN_DET_EN
   always_ff @(posedge clk) begin
      if (reset)
         bus.overrun <= 1'b0;
      else if ((bus.buffer_reset && (bus.buffer_counter != 4'(PRECHECKLEN))) ||
               (bus.buffer_counter > 4'(PRECHECKLEN)))
         bus.overrun <= 1'b1;
   end
`else
   assign bus.overrun = 1'b0;
`endif

endmodule
